// File: rtl/vec_lsu_pkg.sv
// Shared types and constants for the vector load/store sequencer.
// VLSU_INDEXED_EN (when defined) enables indexed addressing in vec_lsu_seq.
package vec_lsu_pkg;
    localparam int VLEN = 128;
    localparam int ELEN = 32;
    localparam int NL   = VLEN / ELEN;

    typedef enum logic [1:0] {
        MODE_UNIT    = 2'b00,
        MODE_STRIDED = 2'b01,
        MODE_INDEXED = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_MODE     = 2'b10;

    typedef enum logic [1:0] {IDLE, VBEAT, SBEAT, DONE} state_e;

    function automatic logic [ELEN-1:0] lane_word(input logic [VLEN-1:0] v, input logic [1:0] k);
        return v[{k, 5'd0} +: ELEN];
    endfunction

    // Active lanes take fresh memory data, the rest keep the old register value.
    function automatic logic [VLEN-1:0] merge_lanes(input logic [VLEN-1:0] fresh,
                                                    input logic [VLEN-1:0] old,
                                                    input logic [NL-1:0]   act);
        logic [VLEN-1:0] res;
        res = old;
        for (int i = 0; i < NL; i++) begin
            if (act[i]) begin
                res[i*ELEN +: ELEN] = fresh[i*ELEN +: ELEN];
            end else begin
                res[i*ELEN +: ELEN] = old[i*ELEN +: ELEN];
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/vec_lsu_seq_if.sv
// Request, memory and writeback signals of the vector load/store sequencer.
interface vec_lsu_seq_if;
    import vec_lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [1:0]      req_mode;
    logic [31:0]     req_base;
    logic [31:0]     req_stride;
    logic [VLEN-1:0] req_index;
    logic [2:0]      req_vl;
    logic            req_vm;
    logic [NL-1:0]   req_mask;
    logic [VLEN-1:0] req_vs3;
    logic [VLEN-1:0] req_vd_old;
    logic [VLEN-1:0] mem_addr;
    logic [VLEN-1:0] mem_datain;
    logic [3:0]      mem_we;
    logic            mem_vector;
    logic [VLEN-1:0] mem_dataout;
    logic            done;
    logic            wb_valid;
    logic [VLEN-1:0] wb_data;
    logic            err;
    logic [1:0]      err_cause;

    modport slave (
        input  req_valid, req_store, req_mode, req_base, req_stride, req_index,
               req_vl, req_vm, req_mask, req_vs3, req_vd_old, mem_dataout,
        output req_ready, mem_addr, mem_datain, mem_we, mem_vector,
               done, wb_valid, wb_data, err, err_cause
    );

    modport master (
        output req_valid, req_store, req_mode, req_base, req_stride, req_index,
               req_vl, req_vm, req_mask, req_vs3, req_vd_old, mem_dataout,
        input  req_ready, mem_addr, mem_datain, mem_we, mem_vector,
               done, wb_valid, wb_data, err, err_cause
    );
endinterface

// File: rtl/vec_lsu_lane.sv
// One lane of address generation: byte address, active flag and misalignment flag.
module vec_lsu_lane
    import vec_lsu_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [31:0] base,
    input  logic [31:0] stride,
    input  logic [31:0] offset,
    input  logic [1:0]  mode,
    input  logic [2:0]  vl,
    input  logic        vm,
    input  logic        mask_bit,
    output logic [31:0] addr,
    output logic        active,
    output logic        misal
);
    // Address arithmetic wraps modulo 2^32 by construction of the 32-bit adds.
    always_comb begin
        case (mode)
            MODE_UNIT:    addr = base + 32'(4 * LANE);
            MODE_STRIDED: addr = base + stride * 32'(LANE);
            MODE_INDEXED: addr = base + offset;
            default:      addr = base;
        endcase
        active = (3'(LANE) < vl) && (vm || mask_bit);
        misal  = active && (addr[1:0] != 2'b00);
    end
endmodule

// File: rtl/vec_lsu_seq.sv
// Vector load/store sequencer: one vector beat for full-width accesses, one scalar
// beat per lane for partial stores. Indexed mode is legal only with VLSU_INDEXED_EN.
module vec_lsu_seq
    import vec_lsu_pkg::*;
(
    input  logic         clk,
    input  logic         clrn,
    vec_lsu_seq_if.slave bus
);
`ifdef VLSU_INDEXED_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    localparam logic [VLEN-ELEN-1:0] HI_ZERO = {(VLEN-ELEN){1'b0}};

    logic [VLEN-1:0] lane_addr_s;
    logic [NL-1:0]   lane_act_s;
    logic [NL-1:0]   lane_mis_s;
    logic            mode_bad_s;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic [31:0] offset_s;
        assign offset_s = IDX_EN ? bus.req_index[i*ELEN +: ELEN] : 32'd0;
        vec_lsu_lane #(.LANE(i)) u_lane (
            .base     (bus.req_base),
            .stride   (bus.req_stride),
            .offset   (offset_s),
            .mode     (bus.req_mode),
            .vl       (bus.req_vl),
            .vm       (bus.req_vm),
            .mask_bit (bus.req_mask[i]),
            .addr     (lane_addr_s[i*ELEN +: ELEN]),
            .active   (lane_act_s[i]),
            .misal    (lane_mis_s[i])
        );
    end

    assign mode_bad_s = (bus.req_mode == MODE_RSVD) || ((bus.req_mode == MODE_INDEXED) && !IDX_EN);

    state_e          state_r;
    logic            store_r;
    logic [2:0]      vl_r;
    logic [1:0]      k_r;
    logic [NL-1:0]   act_r;
    logic [VLEN-1:0] addr_r;
    logic [VLEN-1:0] vs3_r;
    logic [VLEN-1:0] vd_old_r;
    logic [VLEN-1:0] mem_addr_r;
    logic [VLEN-1:0] mem_datain_r;
    logic [3:0]      mem_we_r;
    logic            mem_vector_r;
    logic            done_r;
    logic            wb_valid_r;
    logic [VLEN-1:0] wb_data_r;
    logic            err_r;
    logic [1:0]      err_cause_r;

    // Sequencer FSM with registered memory beat and completion outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r      <= IDLE;
            store_r      <= 1'b0;
            vl_r         <= 3'd0;
            k_r          <= 2'd0;
            act_r        <= {NL{1'b0}};
            addr_r       <= {VLEN{1'b0}};
            vs3_r        <= {VLEN{1'b0}};
            vd_old_r     <= {VLEN{1'b0}};
            mem_addr_r   <= {VLEN{1'b0}};
            mem_datain_r <= {VLEN{1'b0}};
            mem_we_r     <= 4'h0;
            mem_vector_r <= 1'b0;
            done_r       <= 1'b0;
            wb_valid_r   <= 1'b0;
            wb_data_r    <= {VLEN{1'b0}};
            err_r        <= 1'b0;
            err_cause_r  <= CAUSE_NONE;
        end else begin
            done_r     <= 1'b0;
            wb_valid_r <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_r     <= bus.req_store;
                        vl_r        <= bus.req_vl;
                        vs3_r       <= bus.req_vs3;
                        vd_old_r    <= bus.req_vd_old;
                        addr_r      <= lane_addr_s;
                        act_r       <= lane_act_s;
                        k_r         <= 2'd0;
                        err_cause_r <= CAUSE_NONE;
                        if (mode_bad_s) begin
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            err_r       <= 1'b1;
                            err_cause_r <= CAUSE_MODE;
                        end else if (|lane_mis_s) begin
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            err_r       <= 1'b1;
                            err_cause_r <= CAUSE_MISALIGN;
                        end else if (bus.req_vl == 3'd0) begin
                            state_r    <= DONE;
                            done_r     <= 1'b1;
                            wb_valid_r <= !bus.req_store;
                            if (!bus.req_store) wb_data_r <= bus.req_vd_old;
                        end else if (!bus.req_store || (&lane_act_s)) begin
                            state_r      <= VBEAT;
                            mem_addr_r   <= lane_addr_s;
                            mem_vector_r <= 1'b1;
                            mem_we_r     <= bus.req_store ? 4'hF : 4'h0;
                            mem_datain_r <= bus.req_store ? bus.req_vs3 : {VLEN{1'b0}};
                        end else begin
                            state_r      <= SBEAT;
                            mem_addr_r   <= {HI_ZERO, lane_addr_s[ELEN-1:0]};
                            mem_datain_r <= {HI_ZERO, bus.req_vs3[ELEN-1:0]};
                            mem_we_r     <= lane_act_s[0] ? 4'hF : 4'h0;
                            mem_vector_r <= 1'b0;
                        end
                    end
                end
                VBEAT: begin
                    if (!store_r) wb_data_r <= merge_lanes(bus.mem_dataout, vd_old_r, act_r);
                    wb_valid_r   <= !store_r;
                    done_r       <= 1'b1;
                    state_r      <= DONE;
                    mem_addr_r   <= {VLEN{1'b0}};
                    mem_datain_r <= {VLEN{1'b0}};
                    mem_we_r     <= 4'h0;
                    mem_vector_r <= 1'b0;
                end
                SBEAT: begin
                    if ({1'b0, k_r} == (vl_r - 3'd1)) begin
                        done_r       <= 1'b1;
                        state_r      <= DONE;
                        mem_addr_r   <= {VLEN{1'b0}};
                        mem_datain_r <= {VLEN{1'b0}};
                        mem_we_r     <= 4'h0;
                    end else begin
                        k_r          <= k_r + 2'd1;
                        mem_addr_r   <= {HI_ZERO, lane_word(addr_r, k_r + 2'd1)};
                        mem_datain_r <= {HI_ZERO, lane_word(vs3_r, k_r + 2'd1)};
                        mem_we_r     <= act_r[k_r + 2'd1] ? 4'hF : 4'h0;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_r == IDLE) && clrn;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_datain = mem_datain_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_vector = mem_vector_r;
    assign bus.done       = done_r;
    assign bus.wb_valid   = wb_valid_r;
    assign bus.wb_data    = wb_data_r;
    assign bus.err        = err_r;
    assign bus.err_cause  = err_cause_r;
endmodule

// File: tb/tb_vec_lsu_seq.sv
// Self-checking bench for vec_lsu_seq: directed table, reset-abort sequence and a
// randomized run against a word-array memory reference model.
module tb_vec_lsu_seq;
    import vec_lsu_pkg::*;

    typedef struct packed {
        logic        store;
        logic [1:0]  mode;
        logic [31:0] base;
        logic [31:0] stride;
        logic [127:0] index;
        logic [2:0]  vl;
        logic        vm;
        logic [3:0]  mask;
        logic [127:0] vs3;
        logic [127:0] vd_old;
    } op_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  cause;
        logic [7:0]  lat;
        logic        wbv;
        logic [127:0] wbd;
        logic [3:0]  writes;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic ready_done;
        logic ready_after;
        logic bus_idle;
    } res_t;

    typedef struct packed {
        op_t  op;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    vec_lsu_seq_if bus();
    logic [31:0] dut_mem [64];
    logic [31:0] ref_mem [64];
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    vec_lsu_seq dut (.clk(clk), .clrn(clrn), .bus(bus));

    always #5 clk = ~clk;

    // Memory: combinational read per lane, word write at the clock edge.
    always_comb begin
        bus.mem_dataout = '0;
        for (int i = 0; i < 4; i++)
            bus.mem_dataout[i*32 +: 32] = dut_mem[bus.mem_addr[i*32+2 +: 6]];
    end

    always @(posedge clk) begin
        if (bus.mem_we == 4'hF) begin
            if (bus.mem_vector) begin
                for (int i = 0; i < 4; i++)
                    dut_mem[bus.mem_addr[i*32+2 +: 6]] <= bus.mem_datain[i*32 +: 32];
            end else begin
                dut_mem[bus.mem_addr[7:2]] <= bus.mem_datain[31:0];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string name);
        int mism = 0;
        for (int i = 0; i < 64; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
        check(name, 128'(mism), 128'd0);
    endtask

    // Reference: spec-level address/activity rules applied to the word array ref_mem.
    function automatic exp_t model(input op_t op);
        exp_t e;
        logic [31:0] a [4];
        logic act [4];
        logic mis, all_act, idx_ok;
        int n;
        e = '0;
        mis = 1'b0; all_act = 1'b1; n = 0;
`ifdef VLSU_INDEXED_EN
        idx_ok = 1'b1;
`else
        idx_ok = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            if (op.mode == 2'b00)      a[i] = op.base + 32'(4 * i);
            else if (op.mode == 2'b01) a[i] = op.base + 32'(i) * op.stride;
            else                       a[i] = op.base + op.index[i*32 +: 32];
            act[i] = (i < int'(op.vl)) && (op.vm || op.mask[i]);
            if (act[i] && a[i][1:0] != 2'b00) mis = 1'b1;
            if (!act[i]) all_act = 1'b0;
            if (act[i]) n++;
        end
        if (op.mode == 2'b11 || (op.mode == 2'b10 && !idx_ok)) begin
            e.err = 1'b1; e.cause = 2'b10; e.lat = 8'd1;
        end else if (mis) begin
            e.err = 1'b1; e.cause = 2'b01; e.lat = 8'd1;
        end else if (op.vl == 3'd0) begin
            e.lat = 8'd1; e.wbv = !op.store; e.wbd = op.vd_old;
        end else if (!op.store) begin
            e.lat = 8'd2; e.wbv = 1'b1;
            for (int i = 0; i < 4; i++)
                e.wbd[i*32 +: 32] = act[i] ? ref_mem[a[i][7:2]] : op.vd_old[i*32 +: 32];
        end else begin
            e.lat = all_act ? 8'd2 : 8'(int'(op.vl) + 1);
            e.writes = all_act ? 4'd1 : 4'(n);
            for (int i = 0; i < 4; i++)
                if (act[i]) ref_mem[a[i][7:2]] = op.vs3[i*32 +: 32];
        end
        return e;
    endfunction

    task automatic drive(input op_t op, input logic v);
        bus.req_valid  = v;
        bus.req_store  = op.store;
        bus.req_mode   = op.mode;
        bus.req_base   = op.base;
        bus.req_stride = op.stride;
        bus.req_index  = op.index;
        bus.req_vl     = op.vl;
        bus.req_vm     = op.vm;
        bus.req_mask   = op.mask;
        bus.req_vs3    = op.vs3;
        bus.req_vd_old = op.vd_old;
    endtask

    task automatic run_op(input string tag, input op_t op, output res_t r);
        bit got = 1'b0;
        r = '0;
        @(negedge clk);
        check({tag, " ready_before"}, 128'(bus.req_ready), 128'd1);
        drive(op, 1'b1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_we != 4'h0) r.e.writes = r.e.writes + 4'd1;
            if (bus.done) begin
                got = 1'b1;
                r.e.lat = 8'(c);
                r.e.err = bus.err;
                r.e.wbv = bus.wb_valid;
                r.e.wbd = bus.wb_data;
                r.ready_done = bus.req_ready;
                r.bus_idle = (bus.mem_we == 4'h0) && !bus.mem_vector &&
                             (bus.mem_addr == '0) && (bus.mem_datain == '0);
            end
        end
        @(negedge clk);
        r.ready_after = bus.req_ready;
        r.e.cause = bus.err_cause;
    endtask

    task automatic compare(input string tag, input exp_t e, input res_t r);
        check({tag, " latency"}, 128'(r.e.lat), 128'(e.lat));
        check({tag, " err"}, 128'(r.e.err), 128'(e.err));
        check({tag, " err_cause"}, 128'(r.e.cause), 128'(e.cause));
        check({tag, " wb_valid"}, 128'(r.e.wbv), 128'(e.wbv));
        if (e.wbv) check({tag, " wb_data"}, r.e.wbd, e.wbd);
        check({tag, " write_beats"}, 128'(r.e.writes), 128'(e.writes));
        check({tag, " ready_in_done"}, 128'(r.ready_done), 128'd0);
        check({tag, " ready_after"}, 128'(r.ready_after), 128'd1);
        check({tag, " bus_idle_in_done"}, 128'(r.bus_idle), 128'd1);
        check_mem({tag, " memory"});
    endtask

    function automatic op_t mkop(input logic st, input logic [1:0] md, input logic [31:0] b,
                                 input logic [31:0] s, input logic [127:0] ix, input logic [2:0] vl,
                                 input logic vm, input logic [3:0] mk, input logic [127:0] d3,
                                 input logic [127:0] old);
        op_t o;
        o.store = st; o.mode = md; o.base = b; o.stride = s; o.index = ix;
        o.vl = vl; o.vm = vm; o.mask = mk; o.vs3 = d3; o.vd_old = old;
        return o;
    endfunction

    function automatic exp_t mkexp(input logic er, input logic [1:0] c, input logic [7:0] l,
                                   input logic wv, input logic [127:0] wd, input logic [3:0] w);
        exp_t e;
        e.err = er; e.cause = c; e.lat = l; e.wbv = wv; e.wbd = wd; e.writes = w;
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int s;
        o.store = 1'($urandom_range(0, 1));
        s = int'($urandom_range(0, 15));
        o.mode = (s == 15) ? 2'b11 : 2'(s % 3);
        o.base = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) o.base[1:0] = 2'($urandom_range(1, 3));
        s = int'($urandom_range(0, 32)) - 16;
        o.stride = 32'(s * 4);
        if ($urandom_range(0, 7) == 0) o.stride = o.stride + 32'd2;
        for (int i = 0; i < 4; i++) begin
            o.index[i*32 +: 32] = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) o.index[i*32 +: 2] = 2'b01;
        end
        o.vl = 3'($urandom_range(0, 4));
        o.vm = 1'($urandom_range(0, 1));
        o.mask = 4'($urandom_range(0, 15));
        o.vs3 = {$urandom, $urandom, $urandom, $urandom};
        o.vd_old = {$urandom, $urandom, $urandom, $urandom};
        return o;
    endfunction

    initial begin
        res_t r;
        exp_t em;
        op_t op;
        logic [127:0] aa;
        aa = {4{32'hAAAAAAAA}};
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
            dut_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        ref_mem[10] = 32'h53495459; ref_mem[11] = 32'h49564552;
        ref_mem[12] = 32'h4920554e; ref_mem[13] = 32'h484f5345;
        dut_mem[10] = 32'h53495459; dut_mem[11] = 32'h49564552;
        dut_mem[12] = 32'h4920554e; dut_mem[13] = 32'h484f5345;
        drive('0, 1'b0);

        // Reset state.
        #12;
        check("reset ctrl", 128'({bus.req_ready, bus.done, bus.err, bus.wb_valid, bus.err_cause,
                                  bus.mem_we, bus.mem_vector}), 128'd0);
        check("reset wb_data", bus.wb_data, 128'd0);
        check("reset mem_addr", bus.mem_addr | bus.mem_datain, 128'd0);
        @(negedge clk); @(negedge clk);
        clrn = 1'b1;

        tbl.push_back('{mkop(1'b0, 2'b00, 32'h28, 32'd0, '0, 3'd4, 1'b1, 4'h0, '0, '0),
            mkexp(1'b0, 2'b00, 8'd2, 1'b1, {32'h484f5345, 32'h4920554e, 32'h49564552, 32'h53495459}, 4'd0)});
        tbl.push_back('{mkop(1'b1, 2'b01, 32'h38, 32'd8, '0, 3'd3, 1'b1, 4'h0,
                             {32'h0, 32'h33, 32'h22, 32'h11}, '0),
            mkexp(1'b0, 2'b00, 8'd4, 1'b0, '0, 4'd3)});
        tbl.push_back('{mkop(1'b0, 2'b00, 32'h28, 32'd0, '0, 3'd4, 1'b0, 4'b0101, '0, aa),
            mkexp(1'b0, 2'b00, 8'd2, 1'b1, {32'hAAAAAAAA, 32'h4920554e, 32'hAAAAAAAA, 32'h53495459}, 4'd0)});
        tbl.push_back('{mkop(1'b1, 2'b00, 32'h2A, 32'd0, '0, 3'd4, 1'b1, 4'h0, aa, '0),
            mkexp(1'b1, 2'b01, 8'd1, 1'b0, '0, 4'd0)});
        tbl.push_back('{mkop(1'b1, 2'b00, 32'h40, 32'd0, '0, 3'd0, 1'b1, 4'h0, aa, '0),
            mkexp(1'b0, 2'b00, 8'd1, 1'b0, '0, 4'd0)});
`ifdef VLSU_INDEXED_EN
        tbl.push_back('{mkop(1'b0, 2'b10, 32'h28, 32'd0, {32'h8, 32'h4, 32'hC, 32'h0}, 3'd4, 1'b1, 4'h0, '0, '0),
            mkexp(1'b0, 2'b00, 8'd2, 1'b1, {32'h4920554e, 32'h49564552, 32'h484f5345, 32'h53495459}, 4'd0)});
`else
        tbl.push_back('{mkop(1'b0, 2'b10, 32'h28, 32'd0, {32'h8, 32'h4, 32'hC, 32'h0}, 3'd4, 1'b1, 4'h0, '0, '0),
            mkexp(1'b1, 2'b10, 8'd1, 1'b0, '0, 4'd0)});
`endif
        tbl.push_back('{mkop(1'b0, 2'b00, 32'h3, 32'd0, '0, 3'd0, 1'b1, 4'h0, '0, {4{32'h12345678}}),
            mkexp(1'b0, 2'b00, 8'd1, 1'b1, {4{32'h12345678}}, 4'd0)});
        tbl.push_back('{mkop(1'b0, 2'b11, 32'h20, 32'd0, '0, 3'd0, 1'b1, 4'h0, '0, '0),
            mkexp(1'b1, 2'b10, 8'd1, 1'b0, '0, 4'd0)});
        tbl.push_back('{mkop(1'b1, 2'b00, 32'h80, 32'd0, '0, 3'd4, 1'b1, 4'h0,
                             {32'hD3, 32'hD2, 32'hD1, 32'hD0}, '0),
            mkexp(1'b0, 2'b00, 8'd2, 1'b0, '0, 4'd1)});
        tbl.push_back('{mkop(1'b1, 2'b00, 32'h90, 32'd0, '0, 3'd4, 1'b0, 4'b1011,
                             {32'hE3, 32'hE2, 32'hE1, 32'hE0}, '0),
            mkexp(1'b0, 2'b00, 8'd5, 1'b0, '0, 4'd3)});
        tbl.push_back('{mkop(1'b1, 2'b01, 32'h60, 32'd2, '0, 3'd1, 1'b1, 4'h0, {4{32'hF00D}}, '0),
            mkexp(1'b0, 2'b00, 8'd2, 1'b0, '0, 4'd1)});

        foreach (tbl[i]) begin
            em = model(tbl[i].op);
            run_op($sformatf("dir%0d", i), tbl[i].op, r);
            compare($sformatf("dir%0d", i), tbl[i].e, r);
        end

        // Reset while the second of three scalar store beats is on the bus.
        op = mkop(1'b1, 2'b01, 32'hB8, 32'd8, '0, 3'd3, 1'b1, 4'h0,
                  {32'h0, 32'hCC, 32'hBB, 32'hAA}, '0);
        @(negedge clk);
        drive(op, 1'b1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort beat1 addr", bus.mem_addr, 128'h0C0);
        clrn = 1'b0;
        #1;
        check("abort outputs", 128'({bus.req_ready, bus.done, bus.err, bus.wb_valid, bus.err_cause,
                                     bus.mem_we, bus.mem_vector}), 128'd0);
        check("abort buses", bus.mem_addr | bus.mem_datain | bus.wb_data, 128'd0);
        ref_mem[46] = 32'hAA;
        @(negedge clk); @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("abort ready", 128'(bus.req_ready), 128'd1);
        check("abort no done", 128'(bus.done), 128'd0);
        check_mem("abort memory");

        for (int n = 0; n < 150; n++) begin
            op = rand_op();
            em = model(op);
            run_op($sformatf("rnd%0d", n), op, r);
            compare($sformatf("rnd%0d", n), em, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
